// File: rtl/rtc_time_reader.sv
// Reads the RTC seconds, minutes and hours registers over the multiplexed bus and
// publishes a BCD-validated time snapshot that only ever updates as one unit.
module rtc_time_reader #(
  parameter logic [7:0] ADDR_SEG = 8'h41,
  parameter logic [7:0] ADDR_MIN = 8'h42,
  parameter logic [7:0] ADDR_HOR = 8'h43,
  parameter int         TIMEOUT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic       bus_done,
  input  logic [7:0] dato_in,
  output logic       A_D,
  output logic       W_R,
  output logic [7:0] Direccion,
  output logic       flag_bus,
  output logic       busy,
  output logic [7:0] segundos,
  output logic [7:0] minutos,
  output logic [7:0] horas,
  output logic       time_valid,
  output logic       rd_err
);

  // state | meaning
  // IDLE  | waiting for start with enable
  // ADDR  | address phase for register idx
  // DATA  | data phase, capture dato_in on bus_done
  // NEXT  | advance idx or go validate
  // CHECK | range-check shadows, publish or flag error
  typedef enum logic [2:0] {IDLE, ADDR, DATA, NEXT, CHECK} state_t;

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [1:0]    idx;
  logic [TW-1:0] timer;
  logic [7:0]    sh_seg, sh_min, sh_hor;

  function automatic logic [7:0] addr_of(input logic [1:0] i);
    case (i)
      2'd0:    addr_of = ADDR_SEG;
      2'd1:    addr_of = ADDR_MIN;
      default: addr_of = ADDR_HOR;
    endcase
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] lim);
    bcd_ok = (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= lim);
  endfunction

  logic snap_ok;
  assign snap_ok = bcd_ok(sh_seg, 8'h59) && bcd_ok(sh_min, 8'h59) && bcd_ok(sh_hor, 8'h23);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      timer      <= '0;
      sh_seg     <= 8'h00;
      sh_min     <= 8'h00;
      sh_hor     <= 8'h00;
      A_D        <= 1'b0;
      W_R        <= 1'b0;
      Direccion  <= 8'h00;
      flag_bus   <= 1'b0;
      busy       <= 1'b0;
      segundos   <= 8'h00;
      minutos    <= 8'h00;
      horas      <= 8'h00;
      time_valid <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      W_R        <= 1'b0;
      time_valid <= 1'b0;
      rd_err     <= 1'b0;
      if (!enable) begin
        // losing the grant drops the bus silently and discards partial reads
        state     <= IDLE;
        idx       <= 2'd0;
        timer     <= '0;
        sh_seg    <= 8'h00;
        sh_min    <= 8'h00;
        sh_hor    <= 8'h00;
        A_D       <= 1'b0;
        Direccion <= 8'h00;
        flag_bus  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= ADDR;
              idx       <= 2'd0;
              timer     <= '0;
              A_D       <= 1'b0;
              Direccion <= ADDR_SEG;
              flag_bus  <= 1'b1;
              busy      <= 1'b1;
            end
          end
          ADDR, DATA: begin
            if (bus_done) begin
              timer <= '0;
              if (state == ADDR) begin
                state     <= DATA;
                A_D       <= 1'b1;
                Direccion <= 8'h00;
              end else begin
                state    <= NEXT;
                A_D      <= 1'b0;
                flag_bus <= 1'b0;
                case (idx)
                  2'd0:    sh_seg <= dato_in;
                  2'd1:    sh_min <= dato_in;
                  default: sh_hor <= dato_in;
                endcase
              end
            end else if (timer == TIMER_LAST) begin
              state     <= IDLE;
              timer     <= '0;
              idx       <= 2'd0;
              A_D       <= 1'b0;
              Direccion <= 8'h00;
              flag_bus  <= 1'b0;
              busy      <= 1'b0;
              rd_err    <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          NEXT: begin
            if (idx == 2'd2) begin
              state <= CHECK;
            end else begin
              state     <= ADDR;
              idx       <= idx + 2'd1;
              timer     <= '0;
              A_D       <= 1'b0;
              Direccion <= addr_of(idx + 2'd1);
              flag_bus  <= 1'b1;
            end
          end
          CHECK: begin
            if (snap_ok) begin
              segundos   <= sh_seg;
              minutos    <= sh_min;
              horas      <= sh_hor;
              time_valid <= 1'b1;
            end else begin
              rd_err <= 1'b1;
            end
            state <= IDLE;
            idx   <= 2'd0;
            busy  <= 1'b0;
          end
          default: begin
            state    <= IDLE;
            busy     <= 1'b0;
            flag_bus <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rtc_time_reader.sv
// Bench for rtc_time_reader: a reactive bus responder drives the DUT and a cycle-count
// reference model predicts when time_valid / rd_err appear and what the snapshot holds.
module tb_rtc_time_reader;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset, enable, start, bus_done;
  logic [7:0] dato_in;
  logic       A_D, W_R, flag_bus, busy, time_valid, rd_err;
  logic [7:0] Direccion, segundos, minutos, horas;

  int checks = 0;
  int errors = 0;

  logic [7:0] snap [3];
  int         r_tv, r_err, r_ad_bad, r_wr_bad, r_aborted;
  logic       r_busy_end;
  logic [5:0] r_ab_bits;
  logic [7:0] r_ab_dir;
  logic [7:0] r_addr [$];

  rtc_time_reader #(.ADDR_SEG(8'h41), .ADDR_MIN(8'h42), .ADDR_HOR(8'h43), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .bus_done(bus_done),
    .dato_in(dato_in), .A_D(A_D), .W_R(W_R), .Direccion(Direccion), .flag_bus(flag_bus),
    .busy(busy), .segundos(segundos), .minutos(minutos), .horas(horas),
    .time_valid(time_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  function automatic bit bcd_valid(input logic [7:0] v, input int lim);
    int tens, ones;
    tens = int'(v) / 16;
    ones = int'(v) % 16;
    return (tens < 10) && (ones < 10) && (tens * 10 + ones <= lim);
  endfunction

  // Cycle counts are in clock edges after the edge that samples start.
  function automatic void model(input logic [7:0] v[3], input int d[6], output int tv, output int err);
    int t;
    t = 0; tv = -1; err = -1;
    for (int p = 0; p < 6; p++) begin
      if (d[p] >= TO) begin
        err = t + TO;
        return;
      end
      t += d[p] + 1;
      if (p % 2 == 1) t += 1;
    end
    t += 1;
    if (bcd_valid(v[0], 59) && bcd_valid(v[1], 59) && bcd_valid(v[2], 23)) tv = t;
    else err = t;
  endfunction

  // bus responder: d[p] = cycles after phase entry before bus_done is given
  task automatic run_read(input logic [7:0] v[3], input int d[6], input int abort_ph, input int busy_start_at);
    int ph, cnt;
    logic pf, pad;
    r_addr.delete();
    r_tv = -1; r_err = -1; r_ad_bad = 0; r_wr_bad = 0; r_aborted = 0; r_busy_end = 1'b1;
    ph = -1; cnt = 0; pf = 1'b0; pad = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 6 * (TO + 3) + 20; n++) begin
      if (time_valid) begin r_tv = n; r_busy_end = busy; break; end
      if (rd_err) begin r_err = n; r_busy_end = busy; break; end
      if (W_R) r_wr_bad++;
      if (flag_bus) begin
        if (!pf || A_D != pad) begin
          ph++; cnt = 0;
          if (!A_D) r_addr.push_back(Direccion);
        end else cnt++;
        if (A_D != ph[0]) r_ad_bad++;
        if (A_D && Direccion != 8'h00) r_ad_bad++;
      end
      pf = flag_bus; pad = A_D;
      if (ph == abort_ph && flag_bus && cnt == 0) begin
        enable = 1'b0; bus_done = 1'b0;
        @(posedge clk); #1;
        r_ab_bits = {flag_bus, A_D, W_R, busy, time_valid, rd_err};
        r_ab_dir = Direccion;
        enable = 1'b1;
        r_aborted = 1;
        break;
      end
      start = (n == busy_start_at);
      bus_done = flag_bus && ph >= 0 && ph < 6 && cnt == d[ph];
      dato_in = (flag_bus && A_D && ph >= 0 && ph < 6) ? v[ph / 2] : 8'($urandom);
      @(posedge clk); #1;
    end
    bus_done = 1'b0; start = 1'b0;
  endtask

  task automatic check_snap(input string name);
    checks++;
    if ({segundos, minutos, horas} !== {snap[0], snap[1], snap[2]}) begin
      errors++;
      $display("FAIL %s snapshot got %h/%h/%h want %h/%h/%h", name, segundos, minutos, horas,
               snap[0], snap[1], snap[2]);
    end
  endtask

  task automatic check_run(input string name, input logic [7:0] v[3], input int d[6]);
    int etv, eerr;
    model(v, d, etv, eerr);
    checks++;
    if (r_tv !== etv) begin errors++; $display("FAIL %s time_valid cycle got %0d want %0d", name, r_tv, etv); end
    checks++;
    if (r_err !== eerr) begin errors++; $display("FAIL %s rd_err cycle got %0d want %0d", name, r_err, eerr); end
    checks++;
    if (r_busy_end !== 1'b0) begin errors++; $display("FAIL %s busy at end got %b want 0", name, r_busy_end); end
    if (etv >= 0) snap = v;
    check_snap(name);
  endtask

  task automatic test_reset();
    checks++;
    if ({A_D, W_R, flag_bus, busy, time_valid, rd_err} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 000000", {A_D, W_R, flag_bus, busy, time_valid, rd_err});
    end
    checks++;
    if (Direccion !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", Direccion); end
    snap = '{8'h00, 8'h00, 8'h00};
    check_snap("reset");
  endtask

  task automatic test_nominal();
    logic [7:0] v[3];
    int d[6];
    v = '{8'h37, 8'h42, 8'h09};
    d = '{1, 1, 1, 1, 1, 1};
    run_read(v, d, -1, -1);
    check_run("nominal", v, d);
    checks++;
    if (r_tv !== 16) begin errors++; $display("FAIL nominal_latency got %0d want 16", r_tv); end
    checks++;
    if (r_addr.size() != 3 || r_addr[0] !== 8'h41 || r_addr[1] !== 8'h42 || r_addr[2] !== 8'h43) begin
      errors++; $display("FAIL nominal_addr_seq got %p want 41,42,43", r_addr);
    end
    checks++;
    if (r_ad_bad != 0 || r_wr_bad != 0) begin
      errors++; $display("FAIL nominal_phase_bits got ad_bad=%0d wr_bad=%0d want 0", r_ad_bad, r_wr_bad);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] v[3];
    int d[6];
    d = '{1, 1, 1, 1, 1, 1};
    v = '{8'h59, 8'h59, 8'h23};
    run_read(v, d, -1, -1);
    check_run("boundary_max", v, d);
    v = '{8'h00, 8'h00, 8'h00};
    run_read(v, d, -1, -1);
    check_run("boundary_zero", v, d);
  endtask

  task automatic test_range_err();
    logic [7:0] v[3];
    int d[6];
    d = '{1, 1, 1, 1, 1, 1};
    v = '{8'h37, 8'h42, 8'h09};
    run_read(v, d, -1, -1);
    check_run("range_prep", v, d);
    v = '{8'h10, 8'h20, 8'h24};
    run_read(v, d, -1, -1);
    check_run("range_hours24", v, d);
    v = '{8'h10, 8'h5A, 8'h12};
    run_read(v, d, -1, -1);
    check_run("range_min5A", v, d);
  endtask

  task automatic test_timeout();
    logic [7:0] v[3];
    int d[6];
    v = '{8'h11, 8'h22, 8'h13};
    d = '{1, 1, 1, TO, 1, 1};
    run_read(v, d, -1, -1);
    check_run("timeout_min_data", v, d);
    checks++;
    if (r_err !== 23) begin errors++; $display("FAIL timeout_cycle got %0d want 23", r_err); end
    d = '{1, 1, TO - 1, TO - 1, 1, 1};
    run_read(v, d, -1, -1);
    check_run("timeout_edge_wins", v, d);
    v = '{8'h37, 8'h42, 8'h09};
    d = '{1, 1, 1, 1, 1, 1};
    run_read(v, d, -1, -1);
    check_run("timeout_recover", v, d);
  endtask

  task automatic test_abort();
    logic [7:0] v[3];
    int d[6];
    v = '{8'h05, 8'h06, 8'h07};
    d = '{1, 1, 1, 1, 1, 1};
    run_read(v, d, 4, -1);
    checks++;
    if (r_aborted != 1 || r_ab_bits !== 6'b0 || r_ab_dir !== 8'h00) begin
      errors++; $display("FAIL abort_bus got aborted=%0d bits=%b dir=%h want 1/000000/00", r_aborted, r_ab_bits, r_ab_dir);
    end
    check_snap("abort");
    run_read(v, d, -1, 5);
    check_run("busy_start", v, d);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v[3];
    int d[6];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; bus_done = 1'b1;
    @(posedge clk); #1;
    bus_done = 1'b0;
    checks++;
    if (A_D !== 1'b1) begin errors++; $display("FAIL reset_mid_in_data got A_D=%b want 1", A_D); end
    #2 reset = 1'b1;
    #1;
    snap = '{8'h00, 8'h00, 8'h00};
    checks++;
    if ({A_D, W_R, flag_bus, busy, time_valid, rd_err, Direccion} !== 14'b0) begin
      errors++; $display("FAIL reset_mid_outputs got %b want 0", {A_D, W_R, flag_bus, busy, time_valid, rd_err, Direccion});
    end
    check_snap("reset_mid");
    #2 reset = 1'b0;
    @(posedge clk); #1;
    v = '{8'h45, 8'h30, 8'h18};
    d = '{1, 1, 1, 1, 1, 1};
    run_read(v, d, -1, -1);
    check_run("after_reset", v, d);
  endtask

  task automatic test_random();
    logic [7:0] v[3];
    int d[6];
    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 4) == 0) v[k] = 8'($urandom);
        else v[k] = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
      end
      for (int p = 0; p < 6; p++) begin
        if ($urandom_range(0, 15) == 0) d[p] = $urandom_range(TO, TO + 1);
        else d[p] = $urandom_range(0, TO - 1);
      end
      run_read(v, d, -1, -1);
      check_run("random", v, d);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; bus_done = 1'b0; dato_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_nominal();
    test_boundary();
    test_range_err();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
